// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared definitions for the radix-2 FFT pipeline stage buffers:
//   - default transform size, address width and component width
//   - clog2 helper used to derive address widths from a point count
//   - state encoding for the stage write-side controller
//
// No ports; imported by the stage read/write address generators and helpers.
// ---------------------------------------------------------------------------
package fft_pkg;

  // Ceiling log2 for a positive integer; clog2(1) = 0, clog2(16) = 4.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int FFT_N_DEFAULT      = 16;
  localparam int FFT_SIZE_DEFAULT   = clog2(FFT_N_DEFAULT);
  localparam int FFT_DATA_W_DEFAULT = 16;

  // Write-side controller states.
  //   ST_IDLE    : no stage open, waiting for start_stage
  //   ST_ARMED   : stage open, no word yet, watchdog parked
  //   ST_WRITING : at least one word written, watchdog running
  //   ST_DONE    : all N words written, start_next_stage being issued
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_WRITING = 2'd2,
    ST_DONE    = 2'd3
  } fft_wr_state_e;

endpackage : fft_pkg

// File: rtl/fft_bit_reverse.sv
// ---------------------------------------------------------------------------
// fft_bit_reverse
//
// Purely combinational bit reversal over SIZE bits: out_bits[i] takes
// in_bits[SIZE-1-i]. Used to map a natural-order word index onto the
// bit-reversed buffer address needed by a DIF stage; equally usable by
// the read-side address generator.
//
// Ports:
//   in_bits   input  [SIZE-1:0]  natural-order index
//   out_bits  output [SIZE-1:0]  bit-reversed index
// ---------------------------------------------------------------------------
module fft_bit_reverse
  import fft_pkg::*;
#(
  parameter int SIZE = FFT_SIZE_DEFAULT
) (
  input  logic [SIZE-1:0] in_bits,
  output logic [SIZE-1:0] out_bits
);

  // Mirror the index so the MSB of the count drives the LSB of the address.
  always_comb begin
    out_bits = '0;
    for (int i = 0; i < SIZE; i++) begin
      out_bits[i] = in_bits[SIZE-1-i];
    end
  end

endmodule : fft_bit_reverse

// File: rtl/fft_stage1_wr_addr_generator.sv
// ---------------------------------------------------------------------------
// fft_stage1_wr_addr_generator
//
// Write side of a radix-2 FFT pipeline stage. A stage is opened by a
// start_stage pulse while idle; the butterfly results then arrive as a
// stream of words (top then bottom of each butterfly), each flagged by
// in_valid. Every accepted word is registered and presented to the stage
// buffer one cycle later on en_wr / wr_ptr / wr_re / wr_im. After the N-th
// write the block pulses start_next_stage for one cycle and returns idle.
//
// Protocol checking:
//   err_unexpected  sticky, a word arrived while idle or after the stage
//                   had already collected N words (the word is dropped)
//   err_timeout     sticky, the stream stalled for TIMEOUT cycles after
//                   writing began; the stage is abandoned without
//                   start_next_stage
// Both flags clear on the next accepted start_stage or on reset.
//
// Build option:
//   FFT_WR_BITREV_EN  when defined, the buffer is loaded in bit-reversed
//                     order (wr_ptr = bitrev(count)); otherwise the load
//                     is in natural order (wr_ptr = count). Timing is
//                     identical in both builds.
//
// Parameters:
//   N        points per stage, power of two, >= 4
//   SIZE     address width, log2(N)
//   DATA_W   width of each real/imaginary component
//   TIMEOUT  max idle cycles between words once writing began; 0 = off
//
// Ports:
//   clk               input              clock
//   rst_n             input              async active-low reset
//   start_stage       input              arm pulse, honoured only when idle
//   in_valid          input              butterfly word valid
//   in_re / in_im     input  [DATA_W-1:0] butterfly word
//   en_wr             output             buffer write enable
//   wr_ptr            output [SIZE-1:0]  buffer write address
//   wr_re / wr_im     output [DATA_W-1:0] registered write data
//   start_next_stage  output             one-cycle pulse after last write
//   err_unexpected    output             sticky protocol error
//   err_timeout       output             sticky watchdog error
//   busy              output             high whenever a stage is open
// ---------------------------------------------------------------------------
module fft_stage1_wr_addr_generator
  import fft_pkg::*;
#(
  parameter int N       = FFT_N_DEFAULT,
  parameter int SIZE    = clog2(N),
  parameter int DATA_W  = FFT_DATA_W_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_stage,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              en_wr,
  output logic [SIZE-1:0]   wr_ptr,
  output logic [DATA_W-1:0] wr_re,
  output logic [DATA_W-1:0] wr_im,
  output logic              start_next_stage,
  output logic              err_unexpected,
  output logic              err_timeout,
  output logic              busy
);

  // The word counter carries one bit beyond the address so that reaching
  // N never aliases back onto address 0 within a stage.
  localparam int CNT_W  = SIZE + 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(N - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit                WDOG_EN    = (TIMEOUT != 0);

  fft_wr_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              en_wr_q, en_wr_d;
  logic [SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] wr_re_q, wr_re_d;
  logic [DATA_W-1:0] wr_im_q, wr_im_d;
  logic              start_next_q, start_next_d;
  logic              err_unexp_q, err_unexp_d;
  logic              err_timeout_q, err_timeout_d;

  logic [SIZE-1:0]   wr_addr;
  logic              accept;
  logic              last_word;
  logic              wdog_fire;

  // Buffer address for the word currently being accepted.
`ifdef FFT_WR_BITREV_EN
  fft_bit_reverse #(
    .SIZE (SIZE)
  ) u_bit_reverse (
    .in_bits  (cnt_q[SIZE-1:0]),
    .out_bits (wr_addr)
  );
`else
  assign wr_addr = cnt_q[SIZE-1:0];
`endif

  // A word is only taken while a stage is open and not yet complete.
  assign accept    = in_valid && ((state_q == ST_ARMED) || (state_q == ST_WRITING));
  assign last_word = accept && (cnt_q == LAST_CNT);

  // The watchdog only runs once the first word has landed; idle_cnt_q
  // counts the stalled edges already seen, so it fires on the TIMEOUT-th.
  assign wdog_fire = WDOG_EN && (state_q == ST_WRITING) && !in_valid
                     && (idle_cnt_q == IDLE_LIMIT);

  // State and output registers; everything clears asynchronously so a
  // reset mid-stage drops the buffer interface immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idle_cnt_q    <= '0;
      en_wr_q       <= 1'b0;
      wr_ptr_q      <= '0;
      wr_re_q       <= '0;
      wr_im_q       <= '0;
      start_next_q  <= 1'b0;
      err_unexp_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      en_wr_q       <= en_wr_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_re_q       <= wr_re_d;
      wr_im_q       <= wr_im_d;
      start_next_q  <= start_next_d;
      err_unexp_q   <= err_unexp_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Next-state logic. start_stage is only looked at in IDLE, so a pulse
  // arriving mid-stage never restarts the count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_stage) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (last_word)   state_d = ST_DONE;
        else if (accept) state_d = ST_WRITING;
      end
      ST_WRITING: begin
        if (last_word)      state_d = ST_DONE;
        else if (wdog_fire) state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values for the counters and registered outputs. en_wr and
  // start_next_stage default low so they can only ever be one-edge pulses
  // per event; address and data hold between writes.
  always_comb begin
    cnt_d         = cnt_q;
    idle_cnt_d    = idle_cnt_q;
    en_wr_d       = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    wr_re_d       = wr_re_q;
    wr_im_d       = wr_im_q;
    start_next_d  = 1'b0;
    err_unexp_d   = err_unexp_q;
    err_timeout_d = err_timeout_q;

    if (accept) begin
      en_wr_d    = 1'b1;
      wr_ptr_d   = wr_addr;
      wr_re_d    = in_re;
      wr_im_d    = in_im;
      cnt_d      = cnt_q + 1'b1;
      idle_cnt_d = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A word coinciding with the arm pulse is still stray: it is
        // flagged against the freshly cleared error state, not written.
        if (start_stage) begin
          cnt_d         = '0;
          idle_cnt_d    = '0;
          err_timeout_d = 1'b0;
          err_unexp_d   = in_valid;
        end else if (in_valid) begin
          err_unexp_d = 1'b1;
        end
      end
      ST_ARMED: begin
      end
      ST_WRITING: begin
        if (!in_valid && WDOG_EN) begin
          if (wdog_fire) begin
            err_timeout_d = 1'b1;
            idle_cnt_d    = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Any word here is a 17th-style overflow and is dropped.
        start_next_d = 1'b1;
        if (in_valid) err_unexp_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign en_wr            = en_wr_q;
  assign wr_ptr           = wr_ptr_q;
  assign wr_re            = wr_re_q;
  assign wr_im            = wr_im_q;
  assign start_next_stage = start_next_q;
  assign err_unexpected   = err_unexp_q;
  assign err_timeout      = err_timeout_q;
  assign busy             = (state_q != ST_IDLE);

endmodule : fft_stage1_wr_addr_generator

// File: tb/tb_fft_stage1_wr_addr_generator.sv
// ---------------------------------------------------------------------------
// tb_fft_stage1_wr_addr_generator
//
// Drives directed and randomized butterfly streams into the stage-1 write
// address generator and compares every cycle against a stage-level
// reference model (open stage, words collected, stall length).
// ---------------------------------------------------------------------------
module tb_fft_stage1_wr_addr_generator;

  localparam int N       = 16;
  localparam int SIZE    = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic              clk;
  logic              rst_n;
  logic              start_stage;
  logic              in_valid;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              en_wr;
  logic [SIZE-1:0]   wr_ptr;
  logic [DATA_W-1:0] wr_re;
  logic [DATA_W-1:0] wr_im;
  logic              start_next_stage;
  logic              err_unexpected;
  logic              err_timeout;
  logic              busy;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model of one stage.
  bit mOpen;
  bit mPending;
  int mWords;
  int mGap;
  bit mErrUnexp;
  bit mErrTo;

  fft_stage1_wr_addr_generator #(
    .N       (N),
    .SIZE    (SIZE),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_stage      (start_stage),
    .in_valid         (in_valid),
    .in_re            (in_re),
    .in_im            (in_im),
    .en_wr            (en_wr),
    .wr_ptr           (wr_ptr),
    .wr_re            (wr_re),
    .wr_im            (wr_im),
    .start_next_stage (start_next_stage),
    .err_unexpected   (err_unexpected),
    .err_timeout      (err_timeout),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obsVal,
                             input logic [63:0] expVal);
    checkCount++;
    if (obsVal === expVal) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obsVal, expVal, $time);
  endtask

  // Buffer address of the w-th word of a stage.
  function automatic int expAddr(input int w);
    int r;
    r = w;
`ifdef FFT_WR_BITREV_EN
    r = 0;
    for (int i = 0; i < SIZE; i++) r = r * 2 + ((w >> i) % 2);
`endif
    return r;
  endfunction

  // One clock of stimulus: drive on the falling edge, update the model for
  // the rising edge that samples it, then check outputs just after.
  task automatic applyStimulus(input bit sv, input bit iv,
                               input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
    bit expWr;
    bit expSnp;
    int expPtr;
    expWr  = 0;
    expSnp = 0;
    expPtr = 0;
    @(negedge clk);
    start_stage = sv;
    in_valid    = iv;
    in_re       = re;
    in_im       = im;
    @(posedge clk);
    if (mPending) begin
      expSnp   = 1;
      mPending = 0;
      if (iv) mErrUnexp = 1;
    end else if (!mOpen) begin
      if (sv) begin
        mOpen     = 1;
        mWords    = 0;
        mGap      = 0;
        mErrTo    = 0;
        mErrUnexp = iv;
      end else if (iv) begin
        mErrUnexp = 1;
      end
    end else if (iv) begin
      expWr  = 1;
      expPtr = expAddr(mWords);
      mWords++;
      mGap = 0;
      if (mWords == N) begin
        mOpen    = 0;
        mPending = 1;
      end
    end else if (mWords > 0 && TIMEOUT != 0) begin
      mGap++;
      if (mGap == TIMEOUT) begin
        mErrTo = 1;
        mOpen  = 0;
      end
    end
    #1;
    checkOutput("en_wr", en_wr, expWr);
    if (expWr) begin
      checkOutput("wr_ptr", wr_ptr, expPtr);
      checkOutput("wr_re", wr_re, re);
      checkOutput("wr_im", wr_im, im);
    end
    checkOutput("start_next_stage", start_next_stage, expSnp);
    checkOutput("err_unexpected", err_unexpected, mErrUnexp);
    checkOutput("err_timeout", err_timeout, mErrTo);
    checkOutput("busy", busy, mOpen || mPending);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, DATA_W'($urandom), DATA_W'($urandom));
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once.
  task automatic doReset();
    #2;
    rst_n       = 1'b0;
    start_stage = 1'b0;
    in_valid    = 1'b0;
    #1;
    checkOutput("rst en_wr", en_wr, 0);
    checkOutput("rst wr_ptr", wr_ptr, 0);
    checkOutput("rst wr_re", wr_re, 0);
    checkOutput("rst wr_im", wr_im, 0);
    checkOutput("rst start_next_stage", start_next_stage, 0);
    checkOutput("rst err_unexpected", err_unexpected, 0);
    checkOutput("rst err_timeout", err_timeout, 0);
    checkOutput("rst busy", busy, 0);
    mOpen     = 0;
    mPending  = 0;
    mWords    = 0;
    mGap      = 0;
    mErrUnexp = 0;
    mErrTo    = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pickGap();
    int r;
    r = $urandom_range(0, 31);
    if (r < 24) return $urandom_range(0, 3);
    if (r < 28) return $urandom_range(TIMEOUT - 4, TIMEOUT - 1);
    return $urandom_range(TIMEOUT, TIMEOUT + 2);
  endfunction

  initial begin
    rst_n       = 1'b1;
    start_stage = 1'b0;
    in_valid    = 1'b0;
    in_re       = '0;
    in_im       = '0;
    doReset();

    $display("[TB] stray word while idle");
    applyStimulus(0, 1, 16'h1111, 16'h2222);
    idleCycles(2);

    $display("[TB] back-to-back stage, in_re = k");
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < N; k++) applyStimulus(0, 1, DATA_W'(k), DATA_W'($urandom));
    idleCycles(3);

    $display("[TB] overflow: 17 words");
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k <= N; k++) applyStimulus(0, 1, DATA_W'(k + 100), DATA_W'($urandom));
    idleCycles(3);

    $display("[TB] gapped stream, 3-cycle gaps");
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(0, 1, DATA_W'(k), DATA_W'($urandom));
      idleCycles(3);
    end

    $display("[TB] arm with stray word, long arm wait, mid-stage start, max gap");
    applyStimulus(1, 1, 16'hdead, 16'hbeef);
    idleCycles(TIMEOUT + 30);
    for (int k = 0; k < N; k++) begin
      if (k == 8) applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, DATA_W'($urandom), DATA_W'($urandom));
      if (k == 4) idleCycles(TIMEOUT - 1);
    end
    idleCycles(2);

    $display("[TB] watchdog: 5 words then stall");
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, DATA_W'(k), DATA_W'($urandom));
    idleCycles(TIMEOUT + 3);
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < N; k++) applyStimulus(0, 1, DATA_W'(k), DATA_W'($urandom));
    idleCycles(2);

    $display("[TB] reset after word 7, then fresh stage");
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 7; k++) applyStimulus(0, 1, DATA_W'(k), DATA_W'($urandom));
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < N; k++) applyStimulus(0, 1, DATA_W'($urandom), DATA_W'($urandom));
    idleCycles(2);

    $display("[TB] randomized stages");
    for (int s = 0; s < 24; s++) begin
      int nWords;
      int gap;
      if ($urandom_range(0, 5) == 0) applyStimulus(0, 1, DATA_W'($urandom), DATA_W'($urandom));
      applyStimulus(1, $urandom_range(0, 7) == 0, DATA_W'($urandom), DATA_W'($urandom));
      idleCycles($urandom_range(0, 6));
      nWords = N + (($urandom_range(0, 3) == 0) ? 1 : 0);
      for (int k = 0; k < nWords; k++) begin
        applyStimulus(0, 1, DATA_W'($urandom), DATA_W'($urandom));
        gap = pickGap();
        for (int g = 0; g < gap; g++) begin
          applyStimulus($urandom_range(0, 15) == 0, 0, DATA_W'($urandom), DATA_W'($urandom));
        end
      end
      idleCycles($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) doReset();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_fft_stage1_wr_addr_generator
